// File: rtl/washer_pkg.sv
// Shared types and default constants for the washer plant model.
// Holds the plant state encoding, default plant timing/geometry and the
// drum speed ceiling used by washer_plant and plant_tick.
package washer_pkg;

    localparam int unsigned TICK_DIV_DEF   = 1000;
    localparam int unsigned LEVEL_MAX_DEF  = 20;
    localparam int unsigned LEVEL_W_DEF    = 6;
    localparam int unsigned SPIN_TICKS_DEF = 10;

    localparam int unsigned DRUM_SPEED_MAX = 7;
    localparam int unsigned DRUM_SPEED_W   = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILLING  = 3'd1,
        DRAINING = 3'd2,
        SPINNING = 3'd3,
        FAULT    = 3'd4
    } plant_state_e;

endpackage

// File: rtl/washer_plant_if.sv
// Controller-to-actuator interface between the washer controller and the plant.
// master: controller side (drives commands, reads status)
// slave : plant side (reads commands, drives status)
//   inWaterCmd/outWaterCmd/spinCmd : valve and motor commands (levels)
//   doorOpen                       : door switch, synchronous to clk
//   level/full/empty               : water level status
//   drumSpeed/spinDone             : drum status
//   fault                          : latched illegal command combination
interface washer_plant_if #(
    parameter int unsigned LEVEL_W = washer_pkg::LEVEL_W_DEF
);
    logic                                   inWaterCmd;
    logic                                   outWaterCmd;
    logic                                   spinCmd;
    logic                                   doorOpen;
    logic [LEVEL_W-1:0]                     level;
    logic                                   full;
    logic                                   empty;
    logic [washer_pkg::DRUM_SPEED_W-1:0]    drumSpeed;
    logic                                   spinDone;
    logic                                   fault;

    modport master (
        output inWaterCmd, outWaterCmd, spinCmd, doorOpen,
        input  level, full, empty, drumSpeed, spinDone, fault
    );

    modport slave (
        input  inWaterCmd, outWaterCmd, spinCmd, doorOpen,
        output level, full, empty, drumSpeed, spinDone, fault
    );
endinterface

// File: rtl/plant_tick.sv
// Plant time base: free-running counter 0..TICK_DIV-1 that emits a one-cycle
// tick while it holds TICK_DIV-1, then wraps to 0.
// Ports: clk (system clock), resetBtn (async active-high reset), tick (pulse).
module plant_tick #(
    parameter int unsigned TICK_DIV = washer_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic resetBtn,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Prescaler counter
    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/washer_plant.sv
// Behavioural plant model of the washing drum and water circuit. Responds to
// inlet/drain/spin commands with water level, full/empty and spin status.
// Ports: clk (system clock), resetBtn (async active-high reset),
//        bus (washer_plant_if.slave: commands in, status out).
// Optional feature macro: WASHER_PLANT_FAULT_EN -- illegal command
// combinations latch the FAULT state and raise fault; otherwise conflicts are
// resolved by priority drain > fill > spin and fault is tied low.
module washer_plant
    import washer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter int unsigned LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
    parameter int unsigned SPIN_TICKS = SPIN_TICKS_DEF
) (
    input  logic            clk,
    input  logic            resetBtn,
    washer_plant_if.slave   bus
);
    localparam int unsigned SPIN_W = $clog2(SPIN_TICKS + 1);

    plant_state_e             state;
    plant_state_e             state_nxt;
    logic                     tick;
    logic                     fill_en;
    logic                     drain_en;
    logic                     spin_en;
    logic [LEVEL_W-1:0]       level_q;
    logic [LEVEL_W-1:0]       level_nxt;
    logic [DRUM_SPEED_W-1:0]  speed_q;
    logic [DRUM_SPEED_W-1:0]  speed_nxt;
    logic [SPIN_W-1:0]        spin_cnt;
    logic [SPIN_W-1:0]        spin_cnt_nxt;
    logic                     spin_done_q;

    plant_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .resetBtn (resetBtn),
        .tick     (tick)
    );

    // State register
    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
`ifdef WASHER_PLANT_FAULT_EN
    logic conflict;
`endif

    always_comb begin
        state_nxt = state;
`ifdef WASHER_PLANT_FAULT_EN
        conflict  = (bus.inWaterCmd && bus.outWaterCmd)
                 || (bus.spinCmd && (level_q != '0))
                 || (bus.spinCmd && bus.doorOpen);
`endif
        case (state)
            IDLE: begin
                if (bus.outWaterCmd) begin
                    state_nxt = DRAINING;
                end else if (bus.inWaterCmd) begin
                    state_nxt = FILLING;
                end else if (bus.spinCmd && (level_q == '0) && !bus.doorOpen) begin
                    state_nxt = SPINNING;
                end
            end
            FILLING: begin
                if (!bus.inWaterCmd) begin
                    state_nxt = IDLE;
                end
            end
            DRAINING: begin
                if (!bus.outWaterCmd) begin
                    state_nxt = IDLE;
                end
            end
            SPINNING: begin
                if (!bus.spinCmd || bus.doorOpen) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
`ifdef WASHER_PLANT_FAULT_EN
                if (!bus.inWaterCmd && !bus.outWaterCmd && !bus.spinCmd) begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
`ifdef WASHER_PLANT_FAULT_EN
        // Any illegal combination overrides the normal transitions
        if ((state != FAULT) && conflict) begin
            state_nxt = FAULT;
        end
`endif
    end

    // Per-state actuator enables; FAULT and IDLE enable nothing
    always_comb begin
        fill_en  = 1'b0;
        drain_en = 1'b0;
        spin_en  = 1'b0;
        case (state)
            FILLING:  fill_en  = 1'b1;
            DRAINING: drain_en = 1'b1;
            SPINNING: spin_en  = 1'b1;
            default:  ;
        endcase
    end

    // Level, speed and spin progress updates, all keyed off the pre-edge state
    always_comb begin
        level_nxt = level_q;
        if (tick && fill_en && (level_q != LEVEL_W'(LEVEL_MAX))) begin
            level_nxt = level_q + LEVEL_W'(1);
        end else if (tick && drain_en && (level_q != '0)) begin
            level_nxt = level_q - LEVEL_W'(1);
        end

        speed_nxt = speed_q;
        if (tick) begin
            if (spin_en) begin
                if (speed_q != DRUM_SPEED_W'(DRUM_SPEED_MAX)) begin
                    speed_nxt = speed_q + DRUM_SPEED_W'(1);
                end
            end else if (speed_q != '0) begin
                speed_nxt = speed_q - DRUM_SPEED_W'(1);
            end
        end

        // Counter is held at zero outside SPINNING, so entry always starts fresh
        spin_cnt_nxt = '0;
        if (spin_en) begin
            spin_cnt_nxt = spin_cnt;
            if (tick && (spin_cnt != SPIN_W'(SPIN_TICKS))) begin
                spin_cnt_nxt = spin_cnt + SPIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            level_q     <= '0;
            speed_q     <= '0;
            spin_cnt    <= '0;
            spin_done_q <= 1'b0;
        end else begin
            level_q     <= level_nxt;
            speed_q     <= speed_nxt;
            spin_cnt    <= spin_cnt_nxt;
            // Leaving SPINNING clears spinDone on the same edge
            spin_done_q <= (state_nxt == SPINNING) && (spin_cnt_nxt == SPIN_W'(SPIN_TICKS));
        end
    end

`ifdef WASHER_PLANT_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or posedge resetBtn) begin
        if (resetBtn) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_nxt == FAULT);
        end
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.level     = level_q;
    assign bus.full      = (level_q == LEVEL_W'(LEVEL_MAX));
    assign bus.empty     = (level_q == '0);
    assign bus.drumSpeed = speed_q;
    assign bus.spinDone  = spin_done_q;
endmodule
